fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 43 ++++
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: redirect, decode stall, imem port, IF/ID outputs.
// master is the fetch stage, slave is the pipeline/memory around it.
interface fetch_stage_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;

  modport master (
    input  redirect_valid,
    input  redirect_pc,
    input  id_stall,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output imem_req,
    output imem_addr,
    output if_id_valid,
    output if_id_instr,
    output if_id_pc
  );

  modport slave (
    output redirect_valid,
    output redirect_pc,
    output id_stall,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  imem_req,
    input  imem_addr,
    input  if_id_valid,
    input  if_id_instr,
    input  if_id_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch with a one-entry
// skid buffer and redirect/flush handling feeding the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_t;

  state_e      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic [31:0] rbuf;
  logic [31:0] rbuf_pc;
  logic        drop;
  logic        req_en;
  if_id_t      if_id;

  logic accept;
  logic grant;

  assign accept = !bus.id_stall || !if_id.valid;
  assign grant  = bus.imem_req && bus.imem_gnt;

  // req_en keeps the request low for the first cycle out of reset
  assign bus.imem_req    = req_en && (state == FETCH);
  assign bus.imem_addr   = pc;
  assign bus.if_id_valid = if_id.valid;
  assign bus.if_id_instr = if_id.instr;
  assign bus.if_id_pc    = if_id.pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      req_pc  <= '0;
      rbuf    <= '0;
      rbuf_pc <= '0;
      drop    <= 1'b0;
      req_en  <= 1'b0;
      if_id   <= {1'b0, NOP_INSTR, 32'h0};
    end else if (bus.redirect_valid) begin
      req_en      <= 1'b1;
      pc          <= bus.redirect_pc & 32'hFFFF_FFFC;
      if_id.valid <= 1'b0;
      if_id.instr <= NOP_INSTR;
      // an in-flight request must still be retired, but its data dropped
      unique case (state)
        FETCH: begin
          if (grant) begin
            state <= WAIT;
            drop  <= 1'b1;
          end
        end
        WAIT: begin
          state <= bus.imem_rvalid ? FETCH : WAIT;
          drop  <= !bus.imem_rvalid;
        end
        HOLD:    state <= FETCH;
        default: state <= FETCH;
      endcase
    end else begin
      req_en <= 1'b1;
      if (!bus.id_stall) begin
        if_id.valid <= 1'b0;
        if_id.instr <= NOP_INSTR;
      end
      unique case (state)
        FETCH: begin
          if (grant) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            unique case (1'b1)
              drop: begin
                drop  <= 1'b0;
                state <= FETCH;
              end
              !drop && accept: begin
                if_id <= {1'b1, bus.imem_rdata, req_pc};
                state <= FETCH;
              end
              default: begin
                rbuf    <= bus.imem_rdata;
                rbuf_pc <= req_pc;
                state   <= HOLD;
              end
            endcase
          end
        end
        HOLD: begin
          if (!bus.id_stall) begin
            if_id <= {1'b1, rbuf, rbuf_pc};
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios then randomized traffic checked
// against a program-order fetch stream model and a memory queue model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fetch_stage_if bus();

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        auto_mem = 1'b1;
  logic        flush = 1'b0;
  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [31:0] key = 32'h0;
  logic        man_gnt = 1'b0;
  logic        man_rvalid = 1'b0;
  logic [31:0] man_rdata = 32'h0;
  logic [31:0] q_addr[$];
  int          q_wait[$];

  logic        sb_en = 1'b0;
  logic [31:0] exp_pc = 32'h0;
  int          delivered = 0;
  logic        prev_hold = 1'b0;
  logic        prev_redir = 1'b0;
  logic        prev_v = 1'b0;
  logic [31:0] prev_i = 32'h0;
  logic [31:0] prev_p = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Memory: one response per grant, in order, after lat cycles.
  always begin
    @(posedge clk);
    #1;
    if (flush) begin
      q_addr.delete();
      q_wait.delete();
    end
    if (auto_mem) begin
      bus.imem_gnt    = ($urandom_range(99, 0) < gnt_pct);
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
      if (q_addr.size() != 0) begin
        if (q_wait[0] > 0) q_wait[0] = q_wait[0] - 1;
        if (q_wait[0] == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = q_addr[0] ^ key;
        end
      end
    end
    #2;
    if (!auto_mem) begin
      bus.imem_gnt    = man_gnt;
      bus.imem_rvalid = man_rvalid;
      bus.imem_rdata  = man_rdata;
    end
    @(negedge clk);
    if (auto_mem && rst_n && bus.imem_req)
      chk("one_outstanding", q_addr.size(), 32'd0);
    if (auto_mem && bus.imem_rvalid && q_addr.size() != 0) begin
      void'(q_addr.pop_front());
      void'(q_wait.pop_front());
    end
    if (auto_mem && rst_n && bus.imem_req && bus.imem_gnt) begin
      q_addr.push_back(bus.imem_addr);
      q_wait.push_back(int'($urandom_range(lat_max, lat_min)));
    end
  end

  // Stream model: decode consumes IF/ID in program order from exp_pc.
  always @(negedge clk) begin
    if (sb_en) begin
      if (!rst_n) begin
        exp_pc = 32'h0;
        prev_hold = 1'b0;
        prev_redir = 1'b0;
      end else begin
        if (prev_redir)
          chk("flush_valid", {31'b0, bus.if_id_valid}, 32'd0);
        if (prev_hold) begin
          chk("hold_valid", {31'b0, bus.if_id_valid}, {31'b0, prev_v});
          chk("hold_instr", bus.if_id_instr, prev_i);
          chk("hold_pc", bus.if_id_pc, prev_p);
        end
        if (!bus.if_id_valid)
          chk("nop_invalid", bus.if_id_instr, NOP);
        if (bus.imem_req)
          chk("addr_align", {30'b0, bus.imem_addr[1:0]}, 32'd0);
        if (bus.if_id_valid && !bus.id_stall && !bus.redirect_valid) begin
          chk("stream_pc", bus.if_id_pc, exp_pc);
          chk("stream_instr", bus.if_id_instr, exp_pc ^ key);
          exp_pc = exp_pc + 32'd4;
          delivered++;
        end
        if (bus.redirect_valid)
          exp_pc = {bus.redirect_pc[31:2], 2'b00};
        prev_hold = bus.if_id_valid && bus.id_stall && !bus.redirect_valid;
        prev_redir = bus.redirect_valid;
        prev_v = bus.if_id_valid;
        prev_i = bus.if_id_instr;
        prev_p = bus.if_id_pc;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic step();
    nxt();
    smp();
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 20 && !bus.if_id_valid; k++) step();
    chk(tag, {31'b0, bus.if_id_valid}, 32'd1);
  endtask

  task automatic wait_req(input string tag, input logic [31:0] a);
    for (int k = 0; k < 20 && !bus.imem_req; k++) step();
    chk({tag, "_req"}, {31'b0, bus.imem_req}, 32'd1);
    chk(tag, bus.imem_addr, a);
  endtask

  task automatic chk_ifid(input string tag, input logic v,
                          input logic [31:0] i, input logic [31:0] p);
    chk({tag, "_v"}, {31'b0, bus.if_id_valid}, {31'b0, v});
    chk({tag, "_i"}, bus.if_id_instr, i);
    chk({tag, "_p"}, bus.if_id_pc, p);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rst_cnt;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.id_stall = 1'b0;

    // reset state
    repeat (3) step();
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk_ifid("rst", 1'b0, NOP, 32'h0);
    nxt(); rst_n = 1'b1; smp();
    step();
    chk("req_after_rst", {31'b0, bus.imem_req}, 32'd1);
    chk("addr_after_rst", bus.imem_addr, 32'h0);

    // back-to-back stream, one instruction every 2 cycles
    wait_valid("first_valid");
    for (int i = 0; i < 3; i++) begin
      chk_ifid("stream", 1'b1, 32'(4 * i), 32'(4 * i));
      step();
      chk("gap_valid", {31'b0, bus.if_id_valid}, 32'd0);
      nxt();
      if (i == 2) bus.id_stall = 1'b1;
      smp();
    end

    // stalled decode: response goes to the skid buffer
    chk_ifid("pre_hold", 1'b1, 32'd12, 32'd12);
    step();
    chk_ifid("in_hold", 1'b1, 32'd12, 32'd12);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hold_noreq", {31'b0, bus.imem_req}, 32'd0);
      chk_ifid("hold_keep", 1'b1, 32'd12, 32'd12);
    end
    nxt(); bus.id_stall = 1'b0; lat_min = 3; lat_max = 3; smp();
    chk_ifid("hold_last", 1'b1, 32'd12, 32'd12);
    step();
    chk_ifid("hold_out", 1'b1, 32'd16, 32'd16);

    // redirect while waiting on a slow response
    step();
    nxt(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100; smp();
    nxt(); bus.redirect_valid = 1'b0; lat_min = 1; lat_max = 1; smp();
    chk("redir_flush", {31'b0, bus.if_id_valid}, 32'd0);
    wait_req("redir_addr", 32'h100);
    wait_valid("redir_valid");
    chk_ifid("redir_tgt", 1'b1, 32'h100, 32'h100);

    // redirect with stall and valid IF/ID, unaligned target
    nxt(); bus.id_stall = 1'b1; smp();
    wait_valid("stall_load");
    chk_ifid("stall_load", 1'b1, 32'h104, 32'h104);
    nxt(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h203; smp();
    chk("redir_pre", {31'b0, bus.if_id_valid}, 32'd1);
    nxt(); bus.redirect_valid = 1'b0; bus.id_stall = 1'b0; smp();
    chk("redir_stall_v", {31'b0, bus.if_id_valid}, 32'd0);
    chk("redir_stall_nop", bus.if_id_instr, NOP);
    wait_req("redir_align", 32'h200);
    wait_valid("align_valid");
    chk("align_pc", bus.if_id_pc, 32'h200);

    // pc wraps at the top of the address space
    nxt(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC; smp();
    nxt(); bus.redirect_valid = 1'b0; smp();
    wait_req("wrap_req", 32'hFFFF_FFFC);
    step();
    wait_req("wrap_next", 32'h0);
    wait_valid("wrap_v0");
    chk("wrap_pc0", bus.if_id_pc, 32'hFFFF_FFFC);
    step();
    wait_valid("wrap_v1");
    chk("wrap_pc1", bus.if_id_pc, 32'h0);

    // reset mid-WAIT, then a stray response while fetching
    nxt(); auto_mem = 1'b0; rst_n = 1'b0; flush = 1'b1; smp();
    step();
    nxt(); rst_n = 1'b1; flush = 1'b0; smp();
    wait_req("restart", 32'h0);
    nxt(); man_gnt = 1'b1; smp();
    nxt(); man_gnt = 1'b0; rst_n = 1'b0; smp();
    step();
    chk("rst_mid_req", {31'b0, bus.imem_req}, 32'd0);
    chk_ifid("rst_mid", 1'b0, NOP, 32'h0);
    nxt(); rst_n = 1'b1; smp();
    nxt(); man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF; smp();
    chk("stray_req", {31'b0, bus.imem_req}, 32'd1);
    nxt(); man_rvalid = 1'b0; smp();
    chk("stray_ign_v", {31'b0, bus.if_id_valid}, 32'd0);
    chk("stray_ign_a", bus.imem_addr, 32'h0);
    nxt(); man_gnt = 1'b1; smp();
    nxt(); man_gnt = 1'b0; man_rvalid = 1'b1;
    man_rdata = 32'h1234_5678; smp();
    nxt(); man_rvalid = 1'b0; smp();
    chk_ifid("post_stray", 1'b1, 32'h1234_5678, 32'h0);

    // randomized traffic against the stream model
    nxt();
    rst_n = 1'b0; flush = 1'b1; auto_mem = 1'b1; sb_en = 1'b1;
    key = $urandom; gnt_pct = 70; lat_min = 1; lat_max = 3;
    smp();
    step();
    nxt(); rst_n = 1'b1; flush = 1'b0; smp();
    rst_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      nxt();
      bus.id_stall = ($urandom_range(9, 0) < 3);
      bus.redirect_valid = ($urandom_range(24, 0) == 0);
      if ($urandom_range(3, 0) == 0)
        bus.redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
      else
        bus.redirect_pc = 32'($urandom_range(1023, 0));
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) begin
          rst_n = 1'b1;
          flush = 1'b0;
        end
      end else if ($urandom_range(499, 0) == 0) begin
        rst_n = 1'b0;
        flush = 1'b1;
        rst_cnt = 2;
      end
      smp();
    end
    n_cmp++;
    assert (delivered >= 200) else begin
      n_bad++;
      $error("FAIL delivered: observed %0d expected >= 200", delivered);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
